alu_result_fifo: RTL and testbench

- Downstream stage of the 4-bit ALU core.
- Captures each completed result (8-bit result plus zero/carry/overflow flags) on the rising edge of the core's result_valid, and queues it in a small FIFO.
- Presents the oldest entry show-ahead to a slow consumer (pins or a host sequencer), so results are not lost when new operations complete before the previous result has been read.

---
 rtl/alu_result_fifo.sv | 158 +++++++++++++++
 tb/tb_alu_result_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// Downstream result queue for the 4-bit ALU core. Each rising edge of
// result_valid captures {flags, result} into a small circular FIFO. The
// oldest entry is presented show-ahead, so a slow consumer can read it
// and then pop it with a rising edge on rd_req.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   result_valid level from ALU control; a 0->1 edge marks a new result
//   result       ALU result, sampled on the result_valid rising edge
//   flags        {overflow, carry, zero}, sampled with result
//   rd_req       consumer pop request; only its rising edge pops
//   clr          synchronous flush (beats same-cycle push/pop)
//   rd_data      head entry result, 0 when empty
//   rd_flags     head entry flags, 0 when empty
//   empty        no entries stored
//   full         count == DEPTH
//   count        number of stored entries
//   overrun      sticky: a capture was dropped because the FIFO was full
//   drop_cnt     (ALU_FIFO_DROP_CNT_EN only) saturating count of drops
//
// Optional build macro: ALU_FIFO_DROP_CNT_EN adds drop_cnt and derives
// overrun from it.
module alu_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int FLAG_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     result_valid,
  input  logic [DATA_W-1:0]        result,
  input  logic [FLAG_W-1:0]        flags,
  input  logic                     rd_req,
  input  logic                     clr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [FLAG_W-1:0]        rd_flags,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
`ifdef ALU_FIFO_DROP_CNT_EN
  output logic [3:0]               drop_cnt,
`endif
  output logic                     overrun
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + FLAG_W;

  logic               rv_q, rv_d;
  logic               rq_q, rq_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               push_ev, pop_ev;
  logic               is_empty, is_full;
  logic               do_push, do_pop, drop;
  logic               wr_en;
  logic [ENTRY_W-1:0] head;

`ifdef ALU_FIFO_DROP_CNT_EN
  logic [3:0]         drop_cnt_q, drop_cnt_d;
`else
  logic               overrun_q, overrun_d;
`endif

  always_comb begin
    push_ev  = result_valid & ~rv_q;
    pop_ev   = rd_req & ~rq_q;
    is_empty = (count_q == '0);
    is_full  = (count_q == CNT_W'(DEPTH));
    do_pop   = pop_ev & ~is_empty;
    // A full FIFO still accepts a push when a real pop frees the head slot
    // on the same edge.
    do_push  = push_ev & (~is_full | do_pop);
    drop     = push_ev & is_full & ~pop_ev;
    wr_en    = do_push & ~clr;

    rv_d     = result_valid;
    rq_d     = rd_req;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);

`ifdef ALU_FIFO_DROP_CNT_EN
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 4'hF) drop_cnt_d = drop_cnt_q + 4'd1;
`else
    overrun_d = overrun_q | drop;
`endif

    // Flush wins over any event this cycle; the edge registers above still
    // follow their inputs so a held level does not fire after the flush.
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
`ifdef ALU_FIFO_DROP_CNT_EN
      drop_cnt_d = '0;
`else
      overrun_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q     <= 1'b0;
      rq_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef ALU_FIFO_DROP_CNT_EN
      drop_cnt_q <= '0;
`else
      overrun_q  <= 1'b0;
`endif
    end else begin
      rv_q     <= rv_d;
      rq_q     <= rq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef ALU_FIFO_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`else
      overrun_q  <= overrun_d;
`endif
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {flags, result};
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    rd_data  = is_empty ? '0 : head[DATA_W-1:0];
    rd_flags = is_empty ? '0 : head[ENTRY_W-1:DATA_W];
    empty    = is_empty;
    full     = is_full;
    count    = count_q;
`ifdef ALU_FIFO_DROP_CNT_EN
    drop_cnt = drop_cnt_q;
    overrun  = (drop_cnt_q != 4'd0);
`else
    overrun  = overrun_q;
`endif
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       result_valid = 1'b0;
  logic [7:0] result = '0;
  logic [2:0] flags = '0;
  logic       rd_req = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rd_data;
  logic [2:0] rd_flags;
  logic       empty, full, overrun;
  logic [2:0] count;
`ifdef ALU_FIFO_DROP_CNT_EN
  logic [3:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] sb[$];
  logic        exp_overrun = 1'b0;

  alu_result_fifo #(.DEPTH(4), .DATA_W(8), .FLAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .result(result),
    .flags(flags), .rd_req(rd_req), .clr(clr), .rd_data(rd_data),
    .rd_flags(rd_flags), .empty(empty), .full(full), .count(count),
`ifdef ALU_FIFO_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard model.
  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(sb.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(sb.size() == 4));
    chk({tag, ".overrun"}, 32'(overrun), 32'(exp_overrun));
    if (sb.size() == 0) begin
      chk({tag, ".rd_data"},  32'(rd_data),  32'h0);
      chk({tag, ".rd_flags"}, 32'(rd_flags), 32'h0);
    end else begin
      chk({tag, ".rd_data"},  32'(rd_data),  32'(sb[0][7:0]));
      chk({tag, ".rd_flags"}, 32'(rd_flags), 32'(sb[0][10:8]));
    end
  endtask

  // One-cycle result_valid pulse followed by a low cycle.
  task automatic push(input logic [7:0] d, input logic [2:0] f);
    result = d; flags = f; result_valid = 1'b1;
    if (sb.size() < 4) sb.push_back({f, d});
    else exp_overrun = 1'b1;
    step();
    result_valid = 1'b0;
    step();
  endtask

  task automatic pop(input string tag);
    chk_state(tag);
    rd_req = 1'b1;
    if (sb.size() > 0) void'(sb.pop_front());
    step();
    rd_req = 1'b0;
    step();
  endtask

  // Push and pop edges on the same clock.
  task automatic push_pop(input logic [7:0] d, input logic [2:0] f);
    result = d; flags = f; result_valid = 1'b1; rd_req = 1'b1;
    if (sb.size() > 0) void'(sb.pop_front());
    sb.push_back({f, d});
    step();
    result_valid = 1'b0; rd_req = 1'b0;
    step();
  endtask

  initial begin
    // Reset and idle
    step(); step();
    chk_state("reset");
    rst_n = 1'b1;
    step(); step();
    chk_state("idle");

    // Held result_valid produces one push
    result = 8'h2A; flags = 3'b000; result_valid = 1'b1;
    sb.push_back({3'b000, 8'h2A});
    for (int i = 0; i < 5; i++) step();
    chk_state("held_rv");
    result_valid = 1'b0;
    step();
    pop("held_rv_pop");
    chk_state("held_rv_empty");

    // Fill, overrun, drain in order
    for (int i = 1; i <= 4; i++) push(8'(i), 3'(i));
    chk_state("fill4");
    push(8'h05, 3'b111);
    chk_state("overrun");
    for (int i = 0; i < 4; i++) pop($sformatf("drain%0d", i));
    chk_state("drained");

    // Full with simultaneous push/pop, then pointer-wrap rounds
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i), 3'b010);
    push_pop(8'h09, 3'b001);
    chk_state("full_pp");
    for (int i = 0; i < 6; i++) begin
      push_pop(8'hA0 + 8'(i), 3'(i));
      chk_state($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 4; i++) pop($sformatf("wdrain%0d", i));
    chk_state("wrap_empty");

    // Pop on empty is ignored
    rd_req = 1'b1; step(); rd_req = 1'b0; step();
    chk_state("pop_empty");

    // Empty with simultaneous push/pop: push survives
    push_pop(8'h7F, 3'b101);
    chk({"empty_pp.count"}, 32'(count), 32'd1);
    chk_state("empty_pp");
    push(8'h33, 3'b011);
    rd_req = 1'b1;
    void'(sb.pop_front());
    for (int i = 0; i < 10; i++) step();
    chk_state("held_rq");
    rd_req = 1'b0;
    step();
    pop("held_rq_pop");
    chk_state("held_rq_empty");

    // clr beats a same-cycle push and clears overrun
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i), 3'b100);
    chk_state("pre_clr");
    clr = 1'b1; result = 8'h55; flags = 3'b110; result_valid = 1'b1;
    step();
    clr = 1'b0;
    sb.delete();
    exp_overrun = 1'b0;
    step();
    chk_state("clr");
    result_valid = 1'b0;
    step();
    chk_state("clr_no_retrigger");

    // Asynchronous reset mid-fill
    push(8'h61, 3'b001);
    push(8'h62, 3'b010);
    chk_state("pre_rst");
    rst_n = 1'b0;
    #2;
    sb.delete();
    chk_state("async_rst");
    step();
    rst_n = 1'b1;
    step();
    push(8'h70, 3'b000);
    chk_state("post_rst");
    pop("post_rst_pop");

`ifdef ALU_FIFO_DROP_CNT_EN
    for (int i = 0; i < 4; i++) push(8'h80 + 8'(i), 3'b000);
    chk("drop_cnt.zero", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 20; i++) push(8'hEE, 3'b111);
    chk("drop_cnt.sat", 32'(drop_cnt), 32'd15);
    chk_state("drop_full");
    clr = 1'b1; step(); clr = 1'b0; step();
    sb.delete();
    exp_overrun = 1'b0;
    chk("drop_cnt.clr", 32'(drop_cnt), 32'd0);
    chk_state("drop_clr");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
